// File: rtl/core_pkg.sv
// Shared definitions for the 9-bit core: default widths, opcode field
// constants and the fetch-stage state type.
package core_pkg;

  localparam int CORE_PC_W    = 10;
  localparam int CORE_INSTR_W = 9;
  localparam int CORE_LUT_N   = 8;
  localparam int CORE_CNT_W   = 16;

  // Top three opcode bits select an instruction group; the next three
  // select the function within that group.
  localparam logic [2:0] OP_HAS_FUNCA = 3'b110;
  localparam logic [2:0] OP_HAS_FUNCB = 3'b111;
  localparam logic [2:0] FUNCA_HALT   = 3'b111;
  localparam logic [5:0] OP_HALT      = {OP_HAS_FUNCA, FUNCA_HALT};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup table: N entries of absolute target PCs.
// Ports:
//   clk, rst_n      clock, async active-low clear of all entries
//   we, wr_idx,     synchronous write port
//   wr_data
//   rd_idx, rd_data combinational read port (returns pre-write contents
//                   when reading the entry being written this cycle)
module branch_lut
  import core_pkg::*;
#(
  parameter int N = CORE_LUT_N,
  parameter int W = CORE_PC_W,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/instr_fetch.sv
// Program counter and instruction-issue stage.
// Walks ROM addresses, passes fetched instructions straight to the decoder,
// redirects through the branch-target LUT on a taken branch (one-cycle
// bubble), stops on HALT and counts retired instructions.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      pulse: begin execution at PC 0 (IDLE/HALTED only)
//   instr_addr / instr_data    ROM address (registered PC) / data (1-cycle latency)
//   instr_out, instr_valid,    instruction to decoder, live flag, its address
//   issued_pc
//   branch, taken              decoder result for instr_out
//   lut_we, lut_idx, lut_data  branch-target LUT write port
//   done, instr_count          HALT retired flag, retired-instruction count
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// FILL    | ROM read of PC 0 in flight, nothing issued
// RUN     | issuing one instruction per cycle (bubble squashes one slot)
// HALTED  | HALT retired, PC frozen, done held until start
module instr_fetch
  import core_pkg::*;
#(
  parameter int PC_W    = CORE_PC_W,
  parameter int INSTR_W = CORE_INSTR_W,
  parameter int LUT_N   = CORE_LUT_N,
  parameter int CNT_W   = CORE_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    issued_pc,
  input  logic               branch,
  input  logic               taken,
  input  logic               lut_we,
  input  logic [2:0]         lut_idx,
  input  logic [PC_W-1:0]    lut_data,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  instr_addr_q, instr_addr_d;
  logic [PC_W-1:0]  issued_pc_q, issued_pc_d;
  logic             bubble_q, bubble_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [PC_W-1:0]  lut_target;
  logic             valid;

  branch_lut #(
    .N (LUT_N),
    .W (PC_W)
  ) u_branch_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (lut_we),
    .wr_idx  (lut_idx),
    .wr_data (lut_data),
    .rd_idx  (instr_data[2:0]),
    .rd_data (lut_target)
  );

  always_comb begin
    state_d       = state_q;
    instr_addr_d  = instr_addr_q;
    issued_pc_d   = issued_pc_q;
    bubble_d      = bubble_q;
    done_d        = done_q;
    instr_count_d = instr_count_q;
    valid         = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d       = ST_FILL;
          instr_addr_d  = '0;
          instr_count_d = '0;
          done_d        = 1'b0;
          bubble_d      = 1'b0;
        end
      end

      ST_FILL: begin
        instr_addr_d = PC_W'(1);
        issued_pc_d  = '0;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        valid = ~bubble_q;
        if (bubble_q) begin
          // Squashed fall-through slot; the redirected fetch is now in flight.
          bubble_d     = 1'b0;
          issued_pc_d  = instr_addr_q;
          instr_addr_d = instr_addr_q + PC_W'(1);
        end else begin
          if (instr_count_q != '1) instr_count_d = instr_count_q + CNT_W'(1);
          if (is_halt(instr_data[INSTR_W-1 -: 6])) begin
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end else if (branch && taken) begin
            instr_addr_d = lut_target;
            bubble_d     = 1'b1;
            issued_pc_d  = instr_addr_q;
          end else begin
            issued_pc_d  = instr_addr_q;
            instr_addr_d = instr_addr_q + PC_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_addr_q  <= '0;
      issued_pc_q   <= '0;
      bubble_q      <= 1'b0;
      done_q        <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_addr_q  <= instr_addr_d;
      issued_pc_q   <= issued_pc_d;
      bubble_q      <= bubble_d;
      done_q        <= done_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_addr  = instr_addr_q;
  assign issued_pc   = issued_pc_q;
  assign instr_out   = instr_data;
  assign instr_valid = valid;
  assign done        = done_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;
  localparam logic [8:0] I_ADD  = 9'b000001_000;
  localparam logic [8:0] I_HALT = 9'b110111_000;
  localparam logic [5:0] OP_BNO = 6'b101000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_data = '0;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic [PC_W-1:0]    issued_pc;
  logic               branch;
  logic               taken;
  logic               lut_we = 1'b0;
  logic [2:0]         lut_idx = '0;
  logic [PC_W-1:0]    lut_data = '0;
  logic               done;
  logic [CNT_W-1:0]   instr_count;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_addr  (instr_addr),
    .instr_data  (instr_data),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .issued_pc   (issued_pc),
    .branch      (branch),
    .taken       (taken),
    .lut_we      (lut_we),
    .lut_idx     (lut_idx),
    .lut_data    (lut_data),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle synchronous read
  logic [INSTR_W-1:0] rom [1024];
  always @(posedge clk) instr_data <= rom[instr_addr];

  // Decoder model: BNO is a branch; it is taken while the budget lasts
  int taken_seen  = 0;
  int taken_limit = 0;
  assign branch = (instr_out[8:3] == OP_BNO);
  assign taken  = branch && (taken_seen < taken_limit);
  always @(posedge clk) if (instr_valid && branch && taken) taken_seen <= taken_seen + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    int                 gap;   // invalid cycles before this issue; -1 = don't care
  } exp_t;
  exp_t sb_q[$];
  int   gap_cnt = 0;

  task automatic push(input int pc, input int gap);
    exp_t e;
    e.pc    = PC_W'(pc);
    e.instr = rom[PC_W'(pc)];
    e.gap   = gap;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      gap_cnt = 0;
    end else if (instr_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_issue", {22'd0, issued_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("issued_pc", {22'd0, issued_pc}, {22'd0, e.pc});
        check("instr_out", {23'd0, instr_out}, {23'd0, e.instr});
        check("instr_addr", {22'd0, instr_addr}, {22'd0, e.pc + PC_W'(1)});
        check("done_while_valid", {31'd0, done}, 32'd0);
        if (e.gap >= 0) check("bubble_gap", gap_cnt, e.gap);
      end
      gap_cnt = 0;
    end else begin
      gap_cnt++;
    end
  end

  task automatic rom_fill_add();
    for (int i = 0; i < 1024; i++) rom[i] = I_ADD;
  endtask

  function automatic logic [8:0] bno(input int op);
    return {OP_BNO, 3'(op)};
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic lut_write(input int idx, input int val);
    @(posedge clk); #1;
    lut_we = 1'b1; lut_idx = 3'(idx); lut_data = PC_W'(val);
    @(posedge clk); #1 lut_we = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic finish_checks(input string tag, input int exp_cnt);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_count"}, {16'd0, instr_count}, exp_cnt);
  endtask

  initial begin
    rom_fill_add();
    rom[4] = I_HALT;

    // Reset state
    #12;
    check("rst_addr", {22'd0, instr_addr}, 0);
    check("rst_pc", {22'd0, issued_pc}, 0);
    check("rst_valid", {31'd0, instr_valid}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_count", {16'd0, instr_count}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Straight-line run to HALT at 4
    push(0, -1);
    for (int p = 1; p <= 4; p++) push(p, 0);
    pulse_start();
    check("fill_addr", {22'd0, instr_addr}, 0);
    check("fill_valid", {31'd0, instr_valid}, 0);
    wait_drain("t1_drain", 20);
    finish_checks("t1", 5);
    repeat (3) @(posedge clk);
    #2;
    check("t1_done_held", {31'd0, done}, 1);
    check("t1_pc_frozen", {22'd0, instr_addr}, 5);

    // Taken branch at 3 -> LUT[2]=20; LUT[2] rewritten in the redirect cycle
    rom_fill_add();
    rom[3] = bno(2); rom[4] = I_HALT; rom[22] = I_HALT;
    lut_write(2, 20);
    taken_limit = taken_seen + 1;
    push(0, -1); push(1, 0); push(2, 0); push(3, 0);
    push(20, 1); push(21, 0); push(22, 0);
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    lut_we = 1'b1; lut_idx = 3'd2; lut_data = PC_W'(50);
    @(posedge clk); #1 lut_we = 1'b0;
    wait_drain("t2_drain", 30);
    finish_checks("t2", 7);

    // Same branch not taken: no bubble
    rom_fill_add();
    rom[3] = bno(2); rom[5] = I_HALT;
    taken_limit = taken_seen;
    push(0, -1);
    for (int p = 1; p <= 5; p++) push(p, 0);
    pulse_start();
    wait_drain("t3_drain", 30);
    finish_checks("t3", 6);

    // Back-to-back taken branches ping-pong between 20 and 30
    rom_fill_add();
    rom[3] = bno(2); rom[20] = bno(1); rom[30] = bno(0); rom[31] = I_HALT;
    lut_write(2, 20);
    lut_write(1, 30);
    lut_write(0, 20);
    taken_limit = taken_seen + 4;
    push(0, -1); push(1, 0); push(2, 0); push(3, 0);
    push(20, 1); push(30, 1); push(20, 1); push(30, 1); push(31, 0);
    pulse_start();
    wait_drain("t4_drain", 40);
    finish_checks("t4", 9);

    // PC wraps 1023 -> 0
    rom_fill_add();
    rom[0] = bno(5); rom[1] = I_HALT;
    lut_write(5, 1021);
    taken_limit = taken_seen + 1;
    push(0, -1); push(1021, 1); push(1022, 0); push(1023, 0); push(0, 0); push(1, 0);
    pulse_start();
    wait_drain("t5_drain", 30);
    finish_checks("t5", 6);

    // Start held through FILL and pulsed in RUN is ignored; reset at PC 7
    rom_fill_add();
    rom[12] = I_HALT;
    taken_limit = taken_seen;
    push(0, -1);
    for (int p = 1; p <= 6; p++) push(p, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_pc7", {22'd0, issued_pc}, 7);
    check("t6_count_before_rst", {16'd0, instr_count}, 7);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_addr", {22'd0, instr_addr}, 0);
    check("t6_rst_pc", {22'd0, issued_pc}, 0);
    check("t6_rst_valid", {31'd0, instr_valid}, 0);
    check("t6_rst_count", {16'd0, instr_count}, 0);
    check("t6_sb_empty", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk) rst_n = 1'b1;

    // Restart after reset: cleared LUT redirects a taken branch to 0
    rom_fill_add();
    rom[0] = bno(2); rom[2] = I_HALT;
    taken_limit = taken_seen + 1;
    push(0, -1); push(0, 1); push(1, 0); push(2, 0);
    pulse_start();
    wait_drain("t6b_drain", 30);
    finish_checks("t6b", 4);

    // Start from HALTED clears done and count
    rom_fill_add();
    rom[2] = I_HALT;
    taken_limit = taken_seen;
    push(0, -1); push(1, 0); push(2, 0);
    pulse_start();
    check("t7_done_clr", {31'd0, done}, 0);
    check("t7_count_clr", {16'd0, instr_count}, 0);
    check("t7_addr_clr", {22'd0, instr_addr}, 0);
    wait_drain("t7_drain", 20);
    finish_checks("t7", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
